// File: rtl/qpi_pkg.sv
// qpi_pkg: command codes, address length and FSM states shared by the QPI PSRAM responder
package qpi_pkg;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;
  localparam logic [7:0] CMD_ENTER_QPI  = 8'h35;
  localparam logic [7:0] CMD_EXIT_QPI   = 8'hF5;
  localparam int ADDR_NIBBLES = 6;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
endpackage

// File: rtl/qpi_edge_sync.sv
// qpi_edge_sync: 2-FF synchronizer with single-cycle rise/fall pulses on the synchronized level
module qpi_edge_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  // s[1] is the synchronized level, s[2] its one-cycle-old copy for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= {3{INIT}};
    else s <= {s[1:0], d};
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/qpi_psram_responder.sv
// qpi_psram_responder: PSRAM-side QPI bus responder backed by an internal byte RAM (optional cmd_err via QPI_RESPONDER_ERR_EN)
module qpi_psram_responder
  import qpi_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int DUMMY_CLKS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_ncs,
  input  logic [3:0] spi_sin,
  output logic [3:0] spi_sout,
  output logic       spi_oe,
  output logic       qpi_mode,
  output logic       busy
`ifdef QPI_RESPONDER_ERR_EN
  ,
  output logic       cmd_err,
  input  logic       cmd_err_clr
`endif
);
  logic clk_rise, clk_fall, ncs_rise, ncs_fall;
  logic [3:0] sin_m, sin_s;
  state_t state;
  logic [7:0] cmd, cnt, cmd_next, wr_data, rd;
  logic cmd_last, half, wr_en;
  logic [MEM_AW-1:0] addr, wr_addr;
  logic [3:0] wnib;
  logic [7:0] mem [2**MEM_AW];

  qpi_edge_sync #(.INIT(1'b0)) u_clk_sync (.clk(clk), .rst_n(rst_n), .d(spi_clk), .rise(clk_rise), .fall(clk_fall));
  qpi_edge_sync #(.INIT(1'b1)) u_ncs_sync (.clk(clk), .rst_n(rst_n), .d(spi_ncs), .rise(ncs_rise), .fall(ncs_fall));

  // data lane synchronized with the same two-flop delay as spi_clk so it lines up with the rise pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sin_s, sin_m} <= '0;
    else {sin_s, sin_m} <= {sin_m, spi_sin};

  assign cmd_next = qpi_mode ? {cmd[3:0], sin_s} : {cmd[6:0], sin_s[0]};
  assign cmd_last = qpi_mode ? (cnt == 8'd1) : (cnt == 8'd7);
  assign rd = mem[addr];
  assign busy = state != IDLE;

  // bus protocol FSM; deselect has priority over any simultaneous spi_clk edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd <= '0;
      cnt <= '0;
      addr <= '0;
      wnib <= '0;
      half <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      spi_sout <= '0;
      spi_oe <= 1'b0;
      qpi_mode <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (ncs_rise) begin
        state <= IDLE;
        spi_oe <= 1'b0;
      end else
        case (state)
          IDLE: if (ncs_fall) begin
            state <= CMD;
            cnt <= '0;
            half <= 1'b0;
          end
          CMD: if (clk_rise) begin
            cmd <= cmd_next;
            cnt <= cmd_last ? 8'd0 : cnt + 8'd1;
            if (cmd_last) begin
              state <= (qpi_mode && (cmd_next == CMD_QUAD_READ || cmd_next == CMD_QUAD_WRITE)) ? ADDR : IGNORE;
              qpi_mode <= qpi_mode ? (cmd_next != CMD_EXIT_QPI) : (cmd_next == CMD_ENTER_QPI);
            end
          end
          ADDR: if (clk_rise) begin
            addr <= MEM_AW'({addr, sin_s});
            cnt <= cnt + 8'd1;
            if (cnt == 8'(ADDR_NIBBLES - 1)) begin
              cnt <= '0;
              half <= 1'b0;
              state <= (cmd == CMD_QUAD_READ) ? DUMMY : WDATA;
            end
          end
          DUMMY: if (clk_rise) cnt <= cnt + 8'd1;
            else if (clk_fall && cnt == 8'(DUMMY_CLKS)) begin
              spi_sout <= rd[7:4];
              spi_oe <= 1'b1;
              half <= 1'b1;
              state <= RDATA;
            end
          RDATA: if (clk_fall) begin
            spi_sout <= half ? rd[3:0] : rd[7:4];
            half <= ~half;
            if (half) addr <= addr + MEM_AW'(1);
          end
          WDATA: if (clk_rise) begin
            wnib <= sin_s;
            half <= ~half;
            if (half) begin
              wr_en <= 1'b1;
              wr_addr <= addr;
              wr_data <= {wnib, sin_s};
              addr <= addr + MEM_AW'(1);
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
    end

  // byte RAM write port, one clk after the second write nibble
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

`ifdef QPI_RESPONDER_ERR_EN
  logic cmd_known, err_set;
  assign cmd_known = qpi_mode ? (cmd_next == CMD_QUAD_READ || cmd_next == CMD_QUAD_WRITE || cmd_next == CMD_EXIT_QPI)
                              : (cmd_next == CMD_ENTER_QPI);
  assign err_set = ncs_rise ? (state == WDATA && half) : (state == CMD && clk_rise && cmd_last && !cmd_known);
  // sticky error flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cmd_err <= 1'b0;
    else cmd_err <= err_set | (cmd_err & ~cmd_err_clr);
`endif
endmodule

// File: doc/qpi_psram_responder.md
Name: qpi_psram_responder

Overview:
- Synthesizable responder for the QPI PSRAM bus. It plays the memory-chip end of the link that qpimem_iface_intl drives as initiator.
- Sits on one nibble lane (spi_sout_a/spi_sin_a or the _b lane) so the interleaved controller can be exercised in simulation and on FPGA loopback without real PSRAM.
- Oversamples spi_clk and spi_ncs with the system clock. Decodes commands and serves reads and writes from an internal byte RAM.

Parameters:
- MEM_AW, 10, byte-address width of internal RAM (depth 2^MEM_AW bytes).
- DUMMY_CLKS, 6, spi_clk cycles between the last address nibble and the first read-data nibble.

Ports:
- clk  in  1  system clock; every flop is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  bus clock from initiator; asynchronous, synchronized internally.
- spi_ncs  in  1  chip select, active low; synchronized internally.
- spi_sin  in  4  data from initiator.
- spi_sout  out  4  data to initiator.
- spi_oe  out  1  high while the responder drives spi_sout.
- qpi_mode  out  1  1 = QPI mode, 0 = SPI mode.
- busy  out  1  high while a transaction is active (state not IDLE).

Behaviour:
- Decided interface facts: one clock, clk; reset rst_n is asynchronous and active-low.
- Input sync: 2-FF synchronizers on spi_clk, spi_ncs and spi_sin. spi_sin uses the same delay as spi_clk so data sampled at a detected edge matches that edge.
- Edge detection is done on the synchronized spi_clk.
- Bus timing requirement: spi_clk high and low phases each ≥ 3 clk cycles.
- Sampling and drive: sample on detected spi_clk rise; update spi_sout on detected fall.
- Reset values: spi_sout=0, spi_oe=0, qpi_mode=0, busy=0, state=IDLE. RAM contents are not reset.
- States:
  - IDLE: wait for synchronized spi_ncs to fall, then go to CMD.
  - CMD, SPI mode: 8 bits on spi_sin[0], MSB first.
  - CMD, QPI mode: 2 nibbles, high nibble first.
  - ADDR: 6 nibbles, MSB first (QPI only). Only addr[MEM_AW-1:0] is used; upper bits are ignored.
  - DUMMY: count DUMMY_CLKS rises. Load the first byte at the final fall.
  - RDATA: drive high nibble then low nibble per byte.
  - WDATA: collect 2 nibbles, then write the byte.
  - IGNORE: discard all bus activity until spi_ncs rises.
- Command decode in SPI mode:
  - 0x35 sets qpi_mode=1 at command completion, then go to IGNORE.
  - Any other command goes to IGNORE.
- Command decode in QPI mode:
  - 0xEB: ADDR → DUMMY → RDATA.
  - 0x38: ADDR → WDATA (no dummy).
  - 0xF5: clears qpi_mode, then IGNORE.
  - Other: IGNORE.
- Read output:
  - spi_oe rises at the same detected fall that puts the first nibble on spi_sout.
  - spi_oe stays high through RDATA and never asserts in any other state.
- Addressing: the byte address increments after each complete byte and wraps modulo 2^MEM_AW.
- Write commit: the RAM write happens in the clk cycle after the second nibble's rise.
- Partial byte: if ncs rises after only one write nibble, nothing is written.
- Deselect: a synchronized spi_ncs rise in any state means IDLE next cycle and spi_oe=0 the same cycle. This applies mid-command, mid-address and mid-burst. qpi_mode is kept.
- Bursts are unbounded; they continue until ncs rises.
- Reset mid-operation: immediate return to reset values. qpi_mode reverts to 0.
- Simultaneous spi_ncs rise and spi_clk edge: deselect wins and the edge is ignored.

Optional Feature:
- Macro QPI_RESPONDER_ERR_EN.
- Defined: adds output cmd_err (1 bit) and input cmd_err_clr (1 bit).
  - cmd_err sets sticky when an unknown command is decoded, or when a burst ends with a partial write byte.
  - cmd_err_clr=1 clears it. If set and clear occur in the same cycle, set wins.
  - Reset value 0.
- Undefined: neither port exists. Behaviour is otherwise identical.

Decomposition:
- Package qpi_pkg holds:
  - command constants CMD_QUAD_READ=8'hEB, CMD_QUAD_WRITE=8'h38, CMD_ENTER_QPI=8'h35, CMD_EXIT_QPI=8'hF5;
  - ADDR_NIBBLES=6;
  - the state enum.
- Sub-module qpi_edge_sync: 2-FF synchronizer plus rise/fall pulse generation, instantiated for spi_clk and spi_ncs.

Test Plan:
- SPI 0x35, then QPI 0x38 at addr 0x000010 with bytes 01 02 03 04, ncs high → qpi_mode=1; RAM[0x10..0x13]=01,02,03,04.
- QPI 0xEB at addr 0x000010, 6 dummy clocks, 4 bytes → nibbles 0,1,0,2,0,3,0,4; spi_oe high only during data.
- Write 0xAA,0xBB at addr 0x3FF with MEM_AW=10 → RAM[0x3FF]=AA, RAM[0x000]=BB; read back matches.
- Assert ncs high after 3 address nibbles → IDLE, spi_oe=0, RAM unchanged; next valid transaction succeeds.
- QPI 0xF5, then SPI 0x35 → qpi_mode goes 0 then 1.
- Pull rst_n low mid-read burst → spi_oe=0 asynchronously, qpi_mode=0, RAM data preserved on later read.
